// File: rtl/maxmin_sort_ctrl_if.sv
// Producer/consumer streams plus the shared max/min unit port for maxmin_sort_ctrl.
// master = controller side, slave = producer/consumer/compare-unit side; no latency of its own.
interface maxmin_sort_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic [WIDTH-1:0] cmp_max;
    logic [WIDTH-1:0] cmp_min;
    logic             busy;
    logic             done;

    modport master (
        input  in_data, in_valid, out_ready, cmp_max, cmp_min,
        output in_ready, out_data, out_valid, cmp_a, cmp_b, busy, done
    );

    modport slave (
        output in_data, in_valid, out_ready, cmp_max, cmp_min,
        input  in_ready, out_data, out_valid, cmp_a, cmp_b, busy, done
    );
endinterface

// File: rtl/maxmin_sort_ctrl.sv
// Bubble-sorts a DEPTH-word block through an external max/min unit; first output (DEPTH-1)^2+1 cycles after last load.
// Backpressure: in_ready only in LOAD, out_data held while out_valid && !out_ready; done pulses the cycle after the last handshake.
module maxmin_sort_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    maxmin_sort_ctrl_if.master bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST2 = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [IW-1:0]   pass;
    logic [IW-1:0]   pos;
    logic [IW-1:0]   pos_nxt;
    logic            done_q;
    logic [WIDTH-1:0] mem [DEPTH];

    assign pos_nxt = pos + IW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOAD;
            wr_idx <= '0;
            rd_idx <= '0;
            pass   <= '0;
            pos    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        if (wr_idx == LAST) begin
                            wr_idx <= '0;
                            state  <= SORT;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                SORT: begin
                    // Fixed schedule: every pass walks every position, no early exit.
                    if (pos == LAST2) begin
                        pos <= '0;
                        if (pass == LAST2) begin
                            pass  <= '0;
                            state <= DRAIN;
                        end else begin
                            pass <= pass + IW'(1);
                        end
                    end else begin
                        pos <= pos_nxt;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (rd_idx == LAST) begin
                            rd_idx <= '0;
                            state  <= LOAD;
                            done_q <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Storage is never cleared; reads are gated by state so stale words never escape.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == LOAD && bus.in_valid) begin
                mem[wr_idx] <= bus.in_data;
            end else if (state == SORT) begin
                mem[pos]     <= bus.cmp_min;
                mem[pos_nxt] <= bus.cmp_max;
            end
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign bus.busy      = (state == SORT);
    assign bus.out_valid = (state == DRAIN);
    assign bus.out_data  = (state == DRAIN) ? mem[rd_idx]  : '0;
    assign bus.cmp_a     = (state == SORT)  ? mem[pos]     : '0;
    assign bus.cmp_b     = (state == SORT)  ? mem[pos_nxt] : '0;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_maxmin_sort_ctrl.sv
// Randomized and directed bench for maxmin_sort_ctrl against a queue-sort reference model.
// Includes a behavioural max/min unit wired to the cmp_* port.
module tb_maxmin_sort_ctrl;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int SORT_CYC = (DEPTH - 1) * (DEPTH - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    maxmin_sort_ctrl_if #(.WIDTH(WIDTH)) bus ();

    maxmin_sort_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.cmp_max = (bus.cmp_a > bus.cmp_b) ? bus.cmp_a : bus.cmp_b;
    assign bus.cmp_min = (bus.cmp_a > bus.cmp_b) ? bus.cmp_b : bus.cmp_a;

    int nvec = 0;
    int nerr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  {31'b0, bus.in_ready},  1);
        check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 0);
        check({tag, "_busy"},      {31'b0, bus.busy},      0);
        check({tag, "_cmp_a"},     {24'b0, bus.cmp_a},     0);
        check({tag, "_cmp_b"},     {24'b0, bus.cmp_b},     0);
        check({tag, "_out_data"},  {24'b0, bus.out_data},  0);
    endtask

    task automatic load_block(input logic [WIDTH-1:0] vals[$], input bit stall, input bit noisy);
        for (int i = 0; i < DEPTH; i++) begin
            if (stall) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = WIDTH'($urandom);
                    check("load_stall_rdy", {31'b0, bus.in_ready}, 1);
                    step();
                end
            end
            bus.in_valid  = 1'b1;
            bus.in_data   = vals[i];
            bus.out_ready = 1'($urandom);
            check("load_rdy", {31'b0, bus.in_ready}, 1);
            check("load_ov",  {31'b0, bus.out_valid}, 0);
            step();
        end
        bus.in_valid = noisy;
        bus.in_data  = WIDTH'($urandom);
    endtask

    task automatic sort_phase(input bit noisy);
        for (int k = 1; k <= SORT_CYC; k++) begin
            check("sort_busy",  {31'b0, bus.busy},      1);
            check("sort_rdy",   {31'b0, bus.in_ready},  0);
            check("sort_ov",    {31'b0, bus.out_valid}, 0);
            check("sort_cmp_x", {31'b0, $isunknown({bus.cmp_a, bus.cmp_b})}, 0);
            bus.in_valid  = noisy;
            bus.in_data   = WIDTH'($urandom);
            bus.out_ready = 1'($urandom);
            step();
        end
        check("latency_ov",   {31'b0, bus.out_valid}, 1);
        check("latency_busy", {31'b0, bus.busy},      0);
    endtask

    task automatic drain_phase(input logic [WIDTH-1:0] exp[$], input int mode, input bit noisy);
        int  idx = 0;
        int  cyc = 0;
        bit  rdy;
        while (idx < DEPTH && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom);
            endcase
            check("drain_ov",   {31'b0, bus.out_valid}, 1);
            check("drain_data", {24'b0, bus.out_data},  {24'b0, exp[idx]});
            check("drain_done", {31'b0, bus.done},      0);
            check("drain_rdy",  {31'b0, bus.in_ready},  0);
            bus.out_ready = rdy;
            bus.in_valid  = noisy;
            bus.in_data   = WIDTH'($urandom);
            step();
            if (rdy) idx++;
            cyc++;
        end
        if (idx != DEPTH) check("drain_timeout", idx, DEPTH);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("done_pulse",    {31'b0, bus.done},      1);
        check("post_in_ready", {31'b0, bus.in_ready},  1);
        check("post_ov",       {31'b0, bus.out_valid}, 0);
        check("post_busy",     {31'b0, bus.busy},      0);
        step();
        check("done_single",   {31'b0, bus.done},      0);
        check("b2b_in_ready",  {31'b0, bus.in_ready},  1);
    endtask

    task automatic run_block(input logic [WIDTH-1:0] vals[$], input bit stall, input int mode,
                             input bit noisy);
        logic [WIDTH-1:0] exp[$];
        exp = vals;
        exp.sort();
        load_block(vals, stall, noisy);
        sort_phase(noisy);
        drain_phase(exp, mode, noisy);
    endtask

    initial begin
        logic [WIDTH-1:0] v[$];
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_idle("reset");
        check("reset_done", {31'b0, bus.done}, 0);

        v = '{8'd30, 8'd20, 8'd25, 8'd35};
        run_block(v, 1'b0, 0, 1'b0);
        v = '{8'd255, 8'd128, 8'd1, 8'd0};
        run_block(v, 1'b0, 0, 1'b0);
        v = '{8'd7, 8'd7, 8'd7, 8'd7};
        run_block(v, 1'b0, 0, 1'b0);
        v = '{8'd0, 8'd0, 8'd0, 8'd0};
        run_block(v, 1'b0, 0, 1'b0);
        v = '{8'd30, 8'd20, 8'd25, 8'd35};
        run_block(v, 1'b0, 1, 1'b0);

        // Reset three cycles into the sort, then a fresh block.
        v = '{8'd200, 8'd100, 8'd50, 8'd25};
        load_block(v, 1'b0, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst_sort");
        v = '{8'd9, 8'd3, 8'd5, 8'd1};
        run_block(v, 1'b0, 0, 1'b0);

        // Reset with a partial load; the partial words must not reappear.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd250;
        step();
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst_load");
        v = '{8'd4, 8'd2, 8'd8, 8'd6};
        run_block(v, 1'b1, 2, 1'b0);

        // in_valid held high with junk data through SORT/DRAIN.
        v = '{8'd90, 8'd10, 8'd60, 8'd40};
        run_block(v, 1'b0, 2, 1'b1);
        v = '{8'd3, 8'd1, 8'd2, 8'd0};
        run_block(v, 1'b0, 0, 1'b0);

        for (int b = 0; b < 20; b++) begin
            v.delete();
            for (int i = 0; i < DEPTH; i++) begin
                v.push_back(($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3))
                                                        : WIDTH'($urandom));
            end
            run_block(v, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
